// File: rtl/sid_table_loader.sv
// sid_table_loader: loads a 2^ADDR_W x DATA_W waveform table from a byte stream, then serves registered reads.
//   clock, reset_n          : single clock, asynchronous active-low reset
//   start                   : begin/restart a load (wins over a byte offered the same cycle)
//   load_valid/load_data    : byte stream, accepted while load_ready=1
//   load_ready, busy        : high exactly while loading
//   wave -> out             : table read address, data one cycle later (0 unless done)
//   done                    : table complete and readable
//   sum                     : modulo-2^16 sum of bytes accepted in the current/last load
module sid_table_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] wave,
   output logic [DATA_W-1:0] out,
   output logic              busy,
   output logic              done,
   output logic [15:0]       sum
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         sum_q, sum_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                we;
   logic [DATA_W-1:0]   mem [2**ADDR_W];
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      we      = 1'b0;
      if (start) begin
         state_d = LOAD;
         addr_d  = '0;
         sum_d   = '0;
      end else if (state_q == LOAD && load_valid) begin
         we     = 1'b1;
         addr_d = addr_q + ADDR_W'(1);
         sum_d  = sum_q + 16'(load_data);
         // last address written: stop instead of wrapping into a second pass
         if (&addr_q) state_d = DONE;
      end
      // a start seen in DONE already blanks the output for the coming LOAD cycle
      out_d = (state_q == DONE && !start) ? mem[wave] : '0;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sum_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         out_q   <= out_d;
      end
   end
   // table RAM is deliberately not reset; done gates every read instead
   always_ff @(posedge clock) begin
      if (we) mem[addr_q] <= load_data;
   end
   assign load_ready = state_q == LOAD;
   assign busy       = state_q == LOAD;
   assign done       = state_q == DONE;
   assign out        = out_q;
   assign sum        = sum_q;
endmodule

// File: doc/sid_table_loader.md
SID_TABLE_LOADER -- requirements
Module: sid_table_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, table address width (2^ADDR_W entries).
REQ-002 SHALL have parameter DATA_W, default 8, table entry width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin (or restart) a table load.
REQ-006 SHALL have port load_valid  input  1  load_data holds a valid byte.
REQ-007 SHALL have port load_data  input  DATA_W  table byte for the current load address.
REQ-008 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port wave  input  ADDR_W  read address (oscillator accumulator bits).
REQ-010 SHALL have port out  output  DATA_W  registered table read data.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port done  output  1  table fully loaded and readable.
REQ-013 SHALL have port sum  output  16  modulo-2^16 sum of bytes accepted in the current or last load.

Function
REQ-014 SHALL implement states IDLE, LOAD, DONE; the internal table SHALL be a 2^ADDR_W x DATA_W RAM.
REQ-015 SHALL, on start=1 in any state, enter LOAD next cycle with write address=0, sum=0, done=0.
REQ-016 SHALL assert load_ready=1 exactly while in LOAD, and 0 in IDLE and DONE.
REQ-017 SHALL accept a byte on each cycle with load_valid=1, load_ready=1 and start=0: write load_data at the write address, increment the address, and add load_data zero-extended to sum (wrap at 2^16).
REQ-018 SHALL, when start=1 and a byte is offered in LOAD on the same cycle, give priority to start: discard the byte, reset the address and sum.
REQ-019 SHALL, after accepting the byte at address 2^ADDR_W-1, enter DONE on the next cycle with done=1, busy=0, load_ready=0; no address wrap-around into a second pass.
REQ-020 SHALL hold the write address and sum unchanged on LOAD cycles with load_valid=0 (no timeout).
REQ-021 SHALL drive busy=1 exactly while in LOAD.
REQ-022 SHALL, in DONE, register out <= table[wave] on every clock edge, so read latency is exactly 1 cycle and a new address is accepted every cycle.
REQ-023 SHALL drive out=0 (registered) in IDLE and LOAD, so partially loaded data is never presented.
REQ-024 SHALL, in IDLE and DONE, ignore load_valid and load_data entirely, with no RAM write and no sum change.
REQ-025 SHALL leave sum stable in DONE until the next start.

Reset
REQ-026 SHALL, while reset_n=0 (asynchronously), force state=IDLE, write address=0, sum=0, out=0, load_ready=0, busy=0, done=0.
REQ-027 SHALL treat reset during LOAD or DONE as invalidating the table: done stays 0 until a complete new load finishes.
REQ-028 SHALL NOT require RAM contents to be cleared by reset.

Verification
REQ-029 SHALL cover full load: reset, start pulse, then 4096 bytes of the sawtooth+triangle combined table (e.g. 0x07E->0x03, 0x0FC->0x07, 0xFFF->0xFF, all others per table) with load_valid held high -> done=1 exactly 1 cycle after the 4096th accept; sum equals the table byte total mod 2^16; reads of wave=0x07E, 0x0FC, 0xFFF return 0x03, 0x07, 0xFF one cycle later.
REQ-030 SHALL cover back-to-back reads in DONE: wave sequence 0x000, 0x07F, 0xFFE on consecutive cycles -> out 0x00, 0x03, 0xFF on the following consecutive cycles.
REQ-031 SHALL cover gappy load: load_valid toggled randomly with 50% duty -> identical table, sum, and done timing relative to the last accept as the full-load case.
REQ-032 SHALL cover restart: start asserted together with valid byte 0xAA after 100 accepts -> byte discarded, sum=0, address=0, then a complete load finishes normally with no 0xAA present.
REQ-033 SHALL cover reset mid-load: reset_n low after 2000 accepts -> all outputs 0 immediately (asynchronously); wave reads return 0x00 until a new load finishes.
REQ-034 SHALL cover ignored traffic: load_valid=1 with data 0x55 in IDLE and in DONE -> load_ready=0, sum unchanged, table contents unchanged on readback.
